// File: rtl/playlist_pkg.sv
// Shared definitions for the playlist controller.
//   state_e      : controller FSM encoding
//   DefaultDepth : default number of playlist slots
//   DefaultSongW : default song index width
//   LfsrSeed     : reset value of the shuffle LFSR
package playlist_pkg;

  typedef enum logic [1:0] {
    StStop  = 2'd0,
    StLoad  = 2'd1,
    StPlay  = 2'd2,
    StPause = 2'd3
  } state_e;

  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned DefaultSongW = 2;
  localparam logic [7:0]  LfsrSeed     = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advancing every cycle.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-low reset, loads LfsrSeed
//   q     : current LFSR state
module lfsr8
  import playlist_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Taps 8,6,5,4 map to bits 7,5,4,3 of a left-shifting register.
  always_comb begin
    q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= LfsrSeed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/playlist_ctrl.sv
// Playlist controller: stores a list of song indices and sequences a player through
// them under play/next/prev button control.
// Build option: define PLAYLIST_SHUFFLE_EN to add the shuffle_en input and an LFSR
// that picks pseudo-random advance targets.
// Ports:
//   clk, reset                      : clock and synchronous active-low reset
//   wr_en, wr_addr, wr_song         : playlist slot write
//   len_we, len_val                 : playlist length load (STOP only, saturates at DEPTH)
//   play_button, next_button,
//   prev_button                     : one-cycle button pulses
//   repeat_en                       : wrap to slot 0 at the end of the list
//   song_done                       : player finished the current song
//   shuffle_en                      : (shuffle build only) random advance
//   play                            : player run enable
//   reset_player                    : one-cycle player restart pulse
//   song, slot                      : current song index and playlist position
//   done                            : one-cycle end-of-playlist pulse
module playlist_ctrl
  import playlist_pkg::*;
#(
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned SONG_W = DefaultSongW,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [SONG_W-1:0] wr_song,
  input  logic              len_we,
  input  logic [IDX_W:0]    len_val,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              repeat_en,
  input  logic              song_done,
`ifdef PLAYLIST_SHUFFLE_EN
  input  logic              shuffle_en,
`endif
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic [IDX_W-1:0]  slot
  ,
  output logic              done
);

  localparam logic [IDX_W:0] LenMax = (IDX_W+1)'(DEPTH);

  state_e            state_q, state_d;
  state_e            resume_q, resume_d;
  logic [IDX_W-1:0]  slot_q, slot_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [IDX_W:0]    len_q, len_d;
  logic              done_q, done_d;
  logic [SONG_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  adv_slot;
  logic              adv_end;
  logic [IDX_W:0]    len_new;

`ifdef PLAYLIST_SHUFFLE_EN
  logic [7:0]        lfsr_q;
  logic [IDX_W:0]    shuf_c;

  lfsr8 u_lfsr8 (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );
`endif

  // Advance target: next slot, wrap to 0, or end of playlist.
  always_comb begin
    adv_slot = '0;
    adv_end  = 1'b0;
    if (({1'b0, slot_q} + (IDX_W+1)'(1)) < len_q) begin
      adv_slot = slot_q + IDX_W'(1);
    end else if (!repeat_en) begin
      adv_end = 1'b1;
    end
`ifdef PLAYLIST_SHUFFLE_EN
    // One conditional subtract folds the LFSR value into [0, len); anything still
    // out of range (len < DEPTH/2) falls back to slot 0.
    shuf_c = {1'b0, lfsr_q[IDX_W-1:0]};
    if (shuf_c >= len_q) shuf_c = shuf_c - len_q;
    if (shuf_c >= len_q) shuf_c = '0;
    if (shuffle_en) begin
      adv_slot = shuf_c[IDX_W-1:0];
      adv_end  = 1'b0;
    end
`endif
  end

  always_comb begin
    len_new = (len_val > LenMax) ? LenMax : len_val;
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    slot_d   = slot_q;
    song_d   = song_q;
    len_d    = len_q;
    done_d   = 1'b0;
    unique case (state_q)
      StStop: begin
        if (len_we) begin
          len_d = len_new;
          if ({1'b0, slot_q} >= len_new) slot_d = '0;
        end
        if (play_button && (len_q != '0)) begin
          state_d  = StLoad;
          resume_d = StPlay;
        end
      end
      // Buttons are deliberately not looked at here.
      StLoad: begin
        song_d  = mem_q[slot_q];
        state_d = resume_q;
      end
      StPlay, StPause: begin
        if (play_button) begin
          state_d = (state_q == StPlay) ? StPause : StPlay;
        end else if (next_button || (song_done && (state_q == StPlay) && !prev_button)) begin
          slot_d = adv_slot;
          if (adv_end) begin
            state_d = StStop;
            done_d  = 1'b1;
          end else begin
            state_d  = StLoad;
            resume_d = state_q;
          end
        end else if (prev_button) begin
          slot_d   = (slot_q == '0) ? '0 : slot_q - IDX_W'(1);
          state_d  = StLoad;
          resume_d = state_q;
        end
      end
      default: state_d = StStop;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StStop;
      resume_q <= StPlay;
      slot_q   <= '0;
      song_q   <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      slot_q   <= slot_d;
      song_q   <= song_d;
      len_q    <= len_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_song;
    end
  end

  assign play         = (state_q == StPlay);
  assign reset_player = (state_q == StLoad);
  assign song         = song_q;
  assign slot         = slot_q;
  assign done         = done_q;

endmodule
